// File: rtl/regfile_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_if
// Bundles the signals between the decode/writeback stages and the register
// bank write-port scheduler.
//   master : the pipeline side. It drives issue requests and writeback
//            requests, and observes the stall, grants, bank write port,
//            scoreboard and error flag.
//   slave  : the scheduler. It receives the requests and drives the
//            responses and the register bank write inputs.
// Signals:
//   iss_valid/iss_sr1/iss_sr2/iss_dr/iss_wen  decode presents an instruction
//   iss_stall                                 hazard, decode must hold
//   alu_valid/alu_dr/alu_data, alu_ready      ALU writeback request/grant
//   mem_valid/mem_dr/mem_data, mem_ready      MEM writeback request/grant
//   rf_write/rf_dr/rf_wrData                  register bank write port
//   busy_mask                                 pending-write scoreboard
//   err_spur                                  sticky spurious-writeback flag
// ---------------------------------------------------------------------------
interface regfile_wb_scheduler_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic            iss_valid;
  logic [AW-1:0]   iss_sr1;
  logic [AW-1:0]   iss_sr2;
  logic [AW-1:0]   iss_dr;
  logic            iss_wen;
  logic            iss_stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_dr;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_dr;
  logic [DW-1:0]   mem_data;
  logic            mem_ready;
  logic            rf_write;
  logic [AW-1:0]   rf_dr;
  logic [DW-1:0]   rf_wrData;
  logic [NREG-1:0] busy_mask;
  logic            err_spur;

  modport master (
    output iss_valid, iss_sr1, iss_sr2, iss_dr, iss_wen,
    output alu_valid, alu_dr, alu_data,
    output mem_valid, mem_dr, mem_data,
    input  iss_stall, alu_ready, mem_ready,
    input  rf_write, rf_dr, rf_wrData, busy_mask, err_spur
  );

  modport slave (
    input  iss_valid, iss_sr1, iss_sr2, iss_dr, iss_wen,
    input  alu_valid, alu_dr, alu_data,
    input  mem_valid, mem_dr, mem_data,
    output iss_stall, alu_ready, mem_ready,
    output rf_write, rf_dr, rf_wrData, busy_mask, err_spur
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
// Schedules the single write port of the 32x32 register bank:
//   - round-robin arbitration of the ALU and MEM writeback stages,
//   - a per-register pending-write scoreboard (busy_mask),
//   - RAW/WAW stall of decode until the bank holds the result.
// Ports:
//   clk      single clock, all state on posedge
//   reset_n  synchronous active-low reset
//   bus      regfile_wb_scheduler_if.slave (issue, ALU/MEM writeback,
//            bank write port, scoreboard, spurious-writeback flag)
// Timing: a writeback handshake in cycle N drives the bank port in N+1; the
// busy bit clears at the edge ending N+1, the same edge the bank stores data.
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  regfile_wb_scheduler_if.slave bus
);

  // Round-robin arbiter state: who received the most recent grant.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t          last_grant_reg;
  grant_t          last_grant_next;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            rf_write_reg;
  logic            rf_write_next;
  logic [AW-1:0]   rf_dr_reg;
  logic [AW-1:0]   rf_dr_next;
  logic [DW-1:0]   rf_data_reg;
  logic [DW-1:0]   rf_data_next;
  logic            err_reg;
  logic            err_next;

  logic            stall;
  logic            issue_set;
  logic            alu_grant;
  logic            mem_grant;
  logic [AW-1:0]   grant_dr;
  logic [DW-1:0]   grant_data;
  logic            grant_live;

  // Hazard detection. busy_reg[0] is always 0, so r0 never stalls.
  always_comb begin
    stall = bus.iss_valid &
            (busy_reg[bus.iss_sr1] | busy_reg[bus.iss_sr2] |
             (bus.iss_wen & busy_reg[bus.iss_dr]));
    issue_set = bus.iss_valid & ~stall & bus.iss_wen & (bus.iss_dr != '0);
  end

  // Arbiter next-state/outputs. On a tie the requester that did not win
  // last time is granted; a lone requester always wins.
  always_comb begin
    alu_grant       = 1'b0;
    mem_grant       = 1'b0;
    last_grant_next = last_grant_reg;
    if (bus.alu_valid && (!bus.mem_valid || last_grant_reg == GRANT_MEM)) begin
      alu_grant = 1'b1;
    end else if (bus.mem_valid) begin
      mem_grant = 1'b1;
    end
    if (alu_grant) begin
      last_grant_next = GRANT_ALU;
    end else if (mem_grant) begin
      last_grant_next = GRANT_MEM;
    end
  end

  // Granted writeback path. A write to r0 completes its handshake but never
  // reaches the bank; the bank port holds its last address/data when idle.
  always_comb begin
    grant_dr      = mem_grant ? bus.mem_dr   : bus.alu_dr;
    grant_data    = mem_grant ? bus.mem_data : bus.alu_data;
    grant_live    = (alu_grant | mem_grant) & (grant_dr != '0);
    rf_write_next = grant_live;
    rf_dr_next    = grant_live ? grant_dr   : rf_dr_reg;
    rf_data_next  = grant_live ? grant_data : rf_data_reg;
    err_next      = err_reg | (grant_live & ~busy_reg[grant_dr]);
  end

  // Scoreboard: the bit written to the bank this cycle clears, a newly
  // accepted destination sets; set after clear so the new pending write wins.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    logic set_bit;
    logic clr_bit;
    assign set_bit       = issue_set & (bus.iss_dr == AW'(gi));
    assign clr_bit       = rf_write_reg & (rf_dr_reg == AW'(gi));
    assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_reg       <= '0;
      rf_write_reg   <= 1'b0;
      rf_dr_reg      <= '0;
      rf_data_reg    <= '0;
      err_reg        <= 1'b0;
      last_grant_reg <= GRANT_MEM;
    end else begin
      busy_reg       <= busy_next;
      rf_write_reg   <= rf_write_next;
      rf_dr_reg      <= rf_dr_next;
      rf_data_reg    <= rf_data_next;
      err_reg        <= err_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign bus.iss_stall = stall;
  assign bus.alu_ready = alu_grant;
  assign bus.mem_ready = mem_grant;
  assign bus.rf_write  = rf_write_reg;
  assign bus.rf_dr     = rf_dr_reg;
  assign bus.rf_wrData = rf_data_reg;
  assign bus.busy_mask = busy_reg;
  assign bus.err_spur  = err_reg;

endmodule
